// File: rtl/ysyx_24070014_lsu_pkg.sv
// Shared widths, RV32 load/store width encodings and FSM state encoding for the LSU.
package ysyx_24070014_lsu_pkg;

   localparam int DATA_LEN = 32;
   localparam int ADDR_LEN = 32;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_e;

   // Reserved encodings fall through to word accesses.
   function automatic logic [1:0] access_size(input logic [2:0] funct3);
      case (funct3)
         LSU_B, LSU_BU: access_size = SZ_BYTE;
         LSU_H, LSU_HU: access_size = SZ_HALF;
         default:       access_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_24070014_lsu_if.sv
// Valid/ready memory bus between the LSU (master) and the data memory (slave).
interface ysyx_24070014_lsu_if;
   import ysyx_24070014_lsu_pkg::*;

   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_LEN-1:0] mem_addr;
   logic                mem_wen;
   logic [DATA_LEN-1:0] mem_wdata;
   logic [3:0]          mem_wstrb;
   logic                mem_resp_valid;
   logic [DATA_LEN-1:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );

endinterface

// File: rtl/ysyx_24070014_lsu_align.sv
// Combinational store lane/strobe generation and load extract/extend.
// YSYX_24070014_LSU_MISALIGN_CHECK_EN enables the misalignment flag; otherwise it is 0.
module ysyx_24070014_lsu_align
   import ysyx_24070014_lsu_pkg::*;
(
   input  logic [1:0]          st_addr_lo,
   input  logic [2:0]          st_funct3,
   input  logic [DATA_LEN-1:0] st_wdata,
   input  logic [1:0]          ld_addr_lo,
   input  logic [2:0]          ld_funct3,
   input  logic [DATA_LEN-1:0] ld_rdata,
   output logic [3:0]          st_wstrb,
   output logic [DATA_LEN-1:0] st_lane_data,
   output logic                misalign,
   output logic [DATA_LEN-1:0] ld_data
);

   logic [7:0]  ld_byte_s;
   logic [15:0] ld_half_s;

   // store data is replicated across all lanes so the strobe alone picks the bytes
   always_comb begin
      st_wstrb     = 4'b1111;
      st_lane_data = st_wdata;
      case (access_size(st_funct3))
         SZ_BYTE: begin
            st_wstrb     = 4'b0001 << st_addr_lo;
            st_lane_data = {4{st_wdata[7:0]}};
         end
         SZ_HALF: begin
            st_wstrb     = 4'b0011 << {st_addr_lo[1], 1'b0};
            st_lane_data = {2{st_wdata[15:0]}};
         end
         default: begin
            st_wstrb     = 4'b1111;
            st_lane_data = st_wdata;
         end
      endcase
   end

`ifdef YSYX_24070014_LSU_MISALIGN_CHECK_EN
   // halves need addr[0]=0, words need addr[1:0]=0
   always_comb begin
      case (access_size(st_funct3))
         SZ_BYTE: misalign = 1'b0;
         SZ_HALF: misalign = st_addr_lo[0];
         default: misalign = (st_addr_lo != 2'b00);
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // byte lane select
   always_comb begin
      case (ld_addr_lo)
         2'b00:   ld_byte_s = ld_rdata[7:0];
         2'b01:   ld_byte_s = ld_rdata[15:8];
         2'b10:   ld_byte_s = ld_rdata[23:16];
         2'b11:   ld_byte_s = ld_rdata[31:24];
         default: ld_byte_s = ld_rdata[7:0];
      endcase
   end

   assign ld_half_s = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

   // sign/zero extension
   always_comb begin
      case (ld_funct3)
         LSU_B:   ld_data = {{(DATA_LEN-8){ld_byte_s[7]}}, ld_byte_s};
         LSU_BU:  ld_data = {{(DATA_LEN-8){1'b0}}, ld_byte_s};
         LSU_H:   ld_data = {{(DATA_LEN-16){ld_half_s[15]}}, ld_half_s};
         LSU_HU:  ld_data = {{(DATA_LEN-16){1'b0}}, ld_half_s};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_24070014_lsu.sv
// RV32 load/store unit: one transaction at a time, IDLE -> REQ -> WAIT -> DONE.
// Build option: YSYX_24070014_LSU_MISALIGN_CHECK_EN reports misaligned H/W accesses via out_err.
module ysyx_24070014_lsu
   import ysyx_24070014_lsu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_LEN-1:0] in_addr,
   input  logic [DATA_LEN-1:0] in_wdata,
   input  logic                in_is_load,
   input  logic                in_is_store,
   input  logic [2:0]          in_funct3,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] out_data,
   output logic                out_err,
   ysyx_24070014_lsu_if.master mem
);

   lsu_state_e          state_r;
   lsu_state_e          state_nxt_s;
   logic [1:0]          addr_lo_r;
   logic [2:0]          funct3_r;
   logic                wen_r;
   logic [DATA_LEN-1:0] out_data_r;
   logic                out_err_r;
   logic [ADDR_LEN-1:0] mem_addr_r;
   logic [DATA_LEN-1:0] mem_wdata_r;
   logic [3:0]          mem_wstrb_r;

   logic                is_mem_s;
   logic                is_store_s;
   logic                accept_s;
   logic                go_mem_s;
   logic [3:0]          st_wstrb_s;
   logic [DATA_LEN-1:0] st_lane_s;
   logic                misalign_s;
   logic [DATA_LEN-1:0] ld_data_s;

   // load wins when both kind bits are set
   assign is_mem_s   = in_is_load | in_is_store;
   assign is_store_s = in_is_store & ~in_is_load;
   assign accept_s   = in_valid & (state_r == ST_IDLE);
   assign go_mem_s   = is_mem_s & ~misalign_s;

   ysyx_24070014_lsu_align u_align (
      .st_addr_lo   (in_addr[1:0]),
      .st_funct3    (in_funct3),
      .st_wdata     (in_wdata),
      .ld_addr_lo   (addr_lo_r),
      .ld_funct3    (funct3_r),
      .ld_rdata     (mem.mem_rdata),
      .st_wstrb     (st_wstrb_s),
      .st_lane_data (st_lane_s),
      .misalign     (misalign_s),
      .ld_data      (ld_data_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) state_nxt_s = go_mem_s ? ST_REQ : ST_DONE;
            else          state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (mem.mem_req_ready) state_nxt_s = ST_WAIT;
            else                   state_nxt_s = ST_REQ;
         end
         ST_WAIT: begin
            if (mem.mem_resp_valid) state_nxt_s = ST_DONE;
            else                    state_nxt_s = ST_WAIT;
         end
         ST_DONE: begin
            if (out_ready) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // request fields are captured on acceptance and held through REQ; result is captured in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_lo_r   <= 2'b00;
         funct3_r    <= 3'b000;
         wen_r       <= 1'b0;
         out_data_r  <= {DATA_LEN{1'b0}};
         out_err_r   <= 1'b0;
         mem_addr_r  <= {ADDR_LEN{1'b0}};
         mem_wdata_r <= {DATA_LEN{1'b0}};
         mem_wstrb_r <= 4'b0000;
      end else if (accept_s) begin
         addr_lo_r  <= in_addr[1:0];
         funct3_r   <= in_funct3;
         out_err_r  <= is_mem_s & misalign_s;
         out_data_r <= is_mem_s ? {DATA_LEN{1'b0}} : in_addr;
         if (go_mem_s) begin
            mem_addr_r  <= {in_addr[ADDR_LEN-1:2], 2'b00};
            wen_r       <= is_store_s;
            mem_wdata_r <= st_lane_s;
            mem_wstrb_r <= is_store_s ? st_wstrb_s : 4'b0000;
         end
      end else if ((state_r == ST_WAIT) && mem.mem_resp_valid) begin
         out_data_r <= wen_r ? {DATA_LEN{1'b0}} : ld_data_s;
      end
   end

   assign in_ready          = (state_r == ST_IDLE);
   assign out_valid         = (state_r == ST_DONE);
   assign out_data          = out_data_r;
   assign out_err           = out_err_r;
   assign mem.mem_req_valid = (state_r == ST_REQ);
   assign mem.mem_addr      = mem_addr_r;
   assign mem.mem_wen       = wen_r;
   assign mem.mem_wdata     = mem_wdata_r;
   assign mem.mem_wstrb     = mem_wstrb_r;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Table-driven bench for ysyx_24070014_lsu with a reactive memory model and a result scoreboard.
module tb_ysyx_24070014_lsu;
   import ysyx_24070014_lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        in_is_load;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;

   ysyx_24070014_lsu_if bus ();

   ysyx_24070014_lsu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .in_is_load  (in_is_load),
      .in_is_store (in_is_store),
      .in_funct3   (in_funct3),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_err     (out_err),
      .mem         (bus)
   );

   typedef struct {
      string       name;
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mword;
      int          req_stall;
      int          out_stall;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_mwdata;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[$];
   int          total;
   int          bad;

   // memory model controls: automatic responder or hand-driven values
   logic        manual;
   logic        man_ready, man_resp;
   logic [31:0] man_rdata;
   logic        auto_ready, auto_resp;
   logic [31:0] auto_rdata;
   int          stall_cnt;
   logic [31:0] mem_word;

   assign bus.mem_req_ready  = manual ? man_ready : auto_ready;
   assign bus.mem_resp_valid = manual ? man_resp  : auto_resp;
   assign bus.mem_rdata      = manual ? man_rdata : auto_rdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Responder: stalls the request stall_cnt cycles, answers the cycle after acceptance.
   initial begin
      logic acc_pend;
      acc_pend   = 1'b0;
      auto_ready = 1'b0;
      auto_resp  = 1'b0;
      auto_rdata = 32'h0;
      forever begin
         @(negedge clk);
         auto_resp = 1'b0;
         if (!rst_n || manual) begin
            acc_pend   = 1'b0;
            auto_ready = 1'b0;
         end else begin
            if (acc_pend) begin
               auto_resp  = 1'b1;
               auto_rdata = mem_word;
            end
            acc_pend = 1'b0;
            if (bus.mem_req_valid && stall_cnt > 0) begin
               stall_cnt  = stall_cnt - 1;
               auto_ready = 1'b0;
            end else if (bus.mem_req_valid) begin
               auto_ready = 1'b1;
               acc_pend   = 1'b1;
            end else begin
               auto_ready = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] mw,
                               input int rs, input int os, input logic [3:0] ws,
                               input logic [31:0] mwd, input logic [31:0] ed,
                               input logic ee, input int el);
      vec_t v;
      v.name = n; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.mword = mw; v.req_stall = rs; v.out_stall = os; v.exp_wstrb = ws;
      v.exp_mwdata = mwd; v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
      return v;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, " ctl"}, {23'd0, in_ready, out_valid, bus.mem_req_valid, bus.mem_wen,
                          out_err, bus.mem_wstrb}, 32'h0000_0100);
      chk({tag, " out_data"}, out_data, 32'h0);
      chk({tag, " mem_addr"}, bus.mem_addr, 32'h0);
      chk({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
   endtask

   task automatic run_vec(input vec_t v);
      int          lat;
      logic        saw_req, fields_ok, held_ok;
      logic [31:0] first_data;
      exp_t        e;
      chk({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
      mem_word    = v.mword;
      stall_cnt   = v.req_stall;
      in_valid    = 1'b1;
      in_is_load  = v.ld;
      in_is_store = v.st;
      in_funct3   = v.f3;
      in_addr     = v.addr;
      in_wdata    = v.wdata;
      sb.push_back('{data: v.exp_data, err: v.exp_err});
      @(posedge clk);
      @(negedge clk);
      in_valid    = 1'b0;
      in_is_load  = 1'b0;
      in_is_store = 1'b0;
      lat = 1; saw_req = 1'b0; fields_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (bus.mem_req_valid) begin
            saw_req = 1'b1;
            if (bus.mem_addr !== {v.addr[31:2], 2'b00} ||
                bus.mem_wen !== (v.exp_wstrb != 4'b0000) ||
                bus.mem_wstrb !== v.exp_wstrb ||
                (v.exp_wstrb != 4'b0000 && bus.mem_wdata !== v.exp_mwdata) ||
                in_ready !== 1'b0)
               fields_ok = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      saw_req = saw_req | bus.mem_req_valid;
      chk({v.name, " latency"}, lat, v.exp_lat);
      chk({v.name, " req_seen"}, {31'd0, saw_req}, {31'd0, (v.exp_lat != 1)});
      if (saw_req) chk({v.name, " req_fields"}, {31'd0, fields_ok}, 32'd1);
      first_data = out_data;
      held_ok    = 1'b1;
      for (int i = 0; i < v.out_stall; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== first_data || bus.mem_req_valid !== 1'b0)
            held_ok = 1'b0;
      end
      if (v.out_stall > 0) chk({v.name, " held"}, {31'd0, held_ok}, 32'd1);
      out_ready = 1'b1;
      e = sb.pop_front();
      chk({v.name, " data"}, out_data, e.data);
      chk({v.name, " err"}, {31'd0, out_err}, {31'd0, e.err});
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({v.name, " idle"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   // Reset during REQ or WAIT, then a stray response that must be ignored.
   task automatic reset_mid(input logic in_wait, input string tag);
      manual      = 1'b1;
      man_ready   = 1'b0;
      man_resp    = 1'b0;
      in_valid    = 1'b1;
      in_is_store = 1'b1;
      in_funct3   = LSU_W;
      in_addr     = 32'h8000_0010;
      in_wdata    = 32'h5A5A_5A5A;
      @(posedge clk);
      @(negedge clk);
      in_valid    = 1'b0;
      in_is_store = 1'b0;
      chk({tag, " req_up"}, {31'd0, bus.mem_req_valid}, 32'd1);
      if (in_wait) begin
         man_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         man_ready = 1'b0;
         chk({tag, " in_wait"}, {30'd0, bus.mem_req_valid, out_valid}, 32'd0);
      end
      #2 rst_n = 1'b0;
      #1 chk_reset(tag);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      man_resp  = 1'b1;
      man_rdata = 32'h1111_1111;
      @(posedge clk);
      @(negedge clk);
      man_resp = 1'b0;
      chk({tag, " ignore_resp"}, {29'd0, in_ready, out_valid, bus.mem_req_valid}, 32'd4);
      manual = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      total = 0; bad = 0;
      in_valid = 1'b0; in_addr = 32'h0; in_wdata = 32'h0;
      in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000; out_ready = 1'b0;
      manual = 1'b0; man_ready = 1'b0; man_resp = 1'b0; man_rdata = 32'h0;
      stall_cnt = 0; mem_word = 32'h0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      w = 32'h80FF_7F01;
      //             name        ld    st    f3      addr          wdata         mword rs os wstrb    mwdata        data          err  lat
      vecs.push_back(mk("lb_sext",  1'b1, 1'b0, LSU_B,  32'h8000_0003, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 3));
      vecs.push_back(mk("lbu",      1'b1, 1'b0, LSU_BU, 32'h8000_0003, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 3));
      vecs.push_back(mk("lh_stall", 1'b1, 1'b0, LSU_H,  32'h8000_0002, 32'h0,        w, 3, 0, 4'b0000, 32'h0,        32'hFFFF_80FF, 1'b0, 6));
      vecs.push_back(mk("lhu_hold", 1'b1, 1'b0, LSU_HU, 32'h8000_0002, 32'h0,        w, 0, 2, 4'b0000, 32'h0,        32'h0000_80FF, 1'b0, 3));
      vecs.push_back(mk("lw",       1'b1, 1'b0, LSU_W,  32'h8000_0000, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h80FF_7F01, 1'b0, 3));
      vecs.push_back(mk("lb_b2",    1'b1, 1'b0, LSU_B,  32'h8000_0002, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FFFF, 1'b0, 3));
      vecs.push_back(mk("lbu_b1",   1'b1, 1'b0, LSU_BU, 32'h8000_0001, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h0000_007F, 1'b0, 3));
      vecs.push_back(mk("lh_lo",    1'b1, 1'b0, LSU_H,  32'h8000_0000, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h0000_7F01, 1'b0, 3));
      vecs.push_back(mk("lw_rsvd",  1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h80FF_7F01, 1'b0, 3));
      vecs.push_back(mk("sb",       1'b0, 1'b1, LSU_B,  32'h8000_0001, 32'h1234_5678, w, 0, 0, 4'b0010, 32'h7878_7878, 32'h0,        1'b0, 3));
      vecs.push_back(mk("sh",       1'b0, 1'b1, LSU_H,  32'h8000_0002, 32'h1234_5678, w, 0, 1, 4'b1100, 32'h5678_5678, 32'h0,        1'b0, 3));
      vecs.push_back(mk("sw_stall", 1'b0, 1'b1, LSU_W,  32'h8000_0004, 32'hCAFE_F00D, w, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 4));
      vecs.push_back(mk("ld_and_st",1'b1, 1'b1, LSU_BU, 32'h8000_0001, 32'hFFFF_FFFF, w, 0, 0, 4'b0000, 32'h0,        32'h0000_007F, 1'b0, 3));
      vecs.push_back(mk("pass",     1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1));
      vecs.push_back(mk("pass_hold",1'b0, 1'b0, LSU_W,  32'h1234_5679, 32'h0,        w, 0, 2, 4'b0000, 32'h0,        32'h1234_5679, 1'b0, 1));
`ifdef YSYX_24070014_LSU_MISALIGN_CHECK_EN
      vecs.push_back(mk("lw_mis",   1'b1, 1'b0, LSU_W,  32'h8000_0002, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1));
      vecs.push_back(mk("sh_mis",   1'b0, 1'b1, LSU_H,  32'h8000_0001, 32'h0000_ABCD, w, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1));
      vecs.push_back(mk("lh_mis",   1'b1, 1'b0, LSU_H,  32'h8000_0003, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1));
`else
      vecs.push_back(mk("lw_mis",   1'b1, 1'b0, LSU_W,  32'h8000_0002, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'h80FF_7F01, 1'b0, 3));
      vecs.push_back(mk("sh_mis",   1'b0, 1'b1, LSU_H,  32'h8000_0001, 32'h0000_ABCD, w, 0, 0, 4'b0011, 32'hABCD_ABCD, 32'h0,        1'b0, 3));
      vecs.push_back(mk("lh_mis",   1'b1, 1'b0, LSU_H,  32'h8000_0003, 32'h0,        w, 0, 0, 4'b0000, 32'h0,        32'hFFFF_80FF, 1'b0, 3));
`endif

      foreach (vecs[i]) run_vec(vecs[i]);

      reset_mid(1'b0, "rst_req");
      reset_mid(1'b1, "rst_wait");
      run_vec(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
